// File: rtl/dwt_pkg.sv
// Shared constants and types for the level-2 DWT stage: widths, Q1.7 filter
// taps for the Daubechies-2 analysis pair, and block packing length.
package dwt_pkg;

  localparam int W_IN    = 9;                   // level-1 input width, kept for hierarchy consistency
  localparam int Y_OUT   = 25;                  // sample / coefficient word width
  localparam int C_IN    = 9;                   // filter tap width (Q1.7)
  localparam int SHIFT   = 7;                   // Q1.7 scale removal
  localparam int TAPS    = 4;
  localparam int BLK_LEN = 6;                   // decimated words per output block
  localparam int ACC_W   = Y_OUT + C_IN + 2;    // full-precision MAC width

  typedef logic signed [Y_OUT-1:0] sample_t;
  typedef logic signed [C_IN-1:0]  coef_t;
  typedef coef_t [0:TAPS-1]        coef_set_t;  // index j multiplies x[n-j]
  typedef logic [BLK_LEN-1:0][Y_OUT-1:0] block_t;  // element 0 is the oldest word
  typedef logic [2:0]              slot_t;

  localparam coef_set_t LO_COEF = '{-9'sd17, 9'sd29, 9'sd107, 9'sd62};
  localparam coef_set_t HI_COEF = '{-9'sd62, 9'sd107, -9'sd29, -9'sd17};

endpackage

// File: rtl/dwt_level2_if.sv
// Sample input and packed coefficient outputs of the level-2 DWT stage.
// The master side feeds samples and consumes blocks; the slave side is the DWT.
interface dwt_level2_if;
  import dwt_pkg::*;

  logic    Lo_D_down_valid;
  sample_t Lo_D_down_y_k;

  sample_t Hi_D2_c_y_6k, Hi_D2_c_y_6k_1, Hi_D2_c_y_6k_2;
  sample_t Hi_D2_c_y_6k_3, Hi_D2_c_y_6k_4, Hi_D2_c_y_6k_5;
  logic    Hi_D2_valid;

  sample_t Lo_D2_c_y_6k, Lo_D2_c_y_6k_1, Lo_D2_c_y_6k_2;
  sample_t Lo_D2_c_y_6k_3, Lo_D2_c_y_6k_4, Lo_D2_c_y_6k_5;
  logic    Lo_D2_valid;

  modport master (
    output Lo_D_down_valid, Lo_D_down_y_k,
    input  Hi_D2_c_y_6k, Hi_D2_c_y_6k_1, Hi_D2_c_y_6k_2,
           Hi_D2_c_y_6k_3, Hi_D2_c_y_6k_4, Hi_D2_c_y_6k_5, Hi_D2_valid,
           Lo_D2_c_y_6k, Lo_D2_c_y_6k_1, Lo_D2_c_y_6k_2,
           Lo_D2_c_y_6k_3, Lo_D2_c_y_6k_4, Lo_D2_c_y_6k_5, Lo_D2_valid
  );

  modport slave (
    input  Lo_D_down_valid, Lo_D_down_y_k,
    output Hi_D2_c_y_6k, Hi_D2_c_y_6k_1, Hi_D2_c_y_6k_2,
           Hi_D2_c_y_6k_3, Hi_D2_c_y_6k_4, Hi_D2_c_y_6k_5, Hi_D2_valid,
           Lo_D2_c_y_6k, Lo_D2_c_y_6k_1, Lo_D2_c_y_6k_2,
           Lo_D2_c_y_6k_3, Lo_D2_c_y_6k_4, Lo_D2_c_y_6k_5, Lo_D2_valid
  );

endinterface

// File: rtl/dwt_fir_decim.sv
// One analysis branch: 4-tap FIR, keep odd-indexed outputs (decimate by 2),
// pack six kept words into a block presented with a one-cycle strobe.
module dwt_fir_decim
  import dwt_pkg::*;
#(
  parameter coef_set_t COEF = LO_COEF
) (
  input  logic    clk,
  input  logic    rstn,       // synchronous, active-high
  input  logic    in_valid,
  input  sample_t in_y,
  output block_t  out_blk,
  output logic    out_valid
);

  sample_t [1:TAPS-1]          dly;     // x[n-1] .. x[n-3]
  sample_t                     taps [TAPS];
  logic signed [ACC_W-1:0]     acc;
  sample_t                     y;
  logic                        phase;   // 1 when the incoming sample has odd n
  slot_t                       slot;
  logic [BLK_LEN-2:0][Y_OUT-1:0] shadow;  // slot 5 goes straight to the output

  // Full-precision MAC over the current sample and delay line, floor-shift, wrap.
  always_comb begin
    taps[0] = in_y;
    for (int j = 1; j < TAPS; j++) taps[j] = dly[j];
    acc = '0;
    for (int j = 0; j < TAPS; j++)
      acc = acc + ACC_W'(coef_t'(COEF[j])) * ACC_W'(taps[j]);
    y = sample_t'(acc >>> SHIFT);
  end

  // Delay line, decimation phase, slot packing and block hand-off.
  always_ff @(posedge clk) begin
    if (rstn) begin
      // NOTE: the shadow slots are reset too, so a block cut short by reset leaves no stale words behind.
      dly       <= '0;
      phase     <= 1'b0;
      slot      <= '0;
      shadow    <= '0;
      out_blk   <= '0;
      out_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let dly[2] take the old dly[1] in the same edge.
      out_valid <= 1'b0;
      if (in_valid) begin
        dly[1] <= in_y;
        for (int j = 2; j < TAPS; j++) dly[j] <= dly[j-1];
        phase <= ~phase;
        if (phase) begin
          if (slot == slot_t'(BLK_LEN - 1)) begin
            out_blk   <= {y, shadow};
            out_valid <= 1'b1;
            slot      <= '0;
          end else begin
            shadow[slot] <= y;
            slot         <= slot + 3'd1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/dwt_level2.sv
// Level-2 DWT: low-pass and high-pass decimating branches share one input
// stream; their packed blocks drive the interface outputs.
module dwt_level2
  import dwt_pkg::*;
(
  input  logic         clk,
  input  logic         rstn,   // synchronous, active-high
  dwt_level2_if.slave  bus
);

  block_t lo_blk, hi_blk;
  logic   lo_valid, hi_valid;

  dwt_fir_decim #(.COEF(LO_COEF)) u_lo (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (bus.Lo_D_down_valid),
    .in_y      (bus.Lo_D_down_y_k),
    .out_blk   (lo_blk),
    .out_valid (lo_valid)
  );

  dwt_fir_decim #(.COEF(HI_COEF)) u_hi (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (bus.Lo_D_down_valid),
    .in_y      (bus.Lo_D_down_y_k),
    .out_blk   (hi_blk),
    .out_valid (hi_valid)
  );

  assign bus.Lo_D2_c_y_6k   = lo_blk[0];
  assign bus.Lo_D2_c_y_6k_1 = lo_blk[1];
  assign bus.Lo_D2_c_y_6k_2 = lo_blk[2];
  assign bus.Lo_D2_c_y_6k_3 = lo_blk[3];
  assign bus.Lo_D2_c_y_6k_4 = lo_blk[4];
  assign bus.Lo_D2_c_y_6k_5 = lo_blk[5];
  assign bus.Lo_D2_valid    = lo_valid;

  assign bus.Hi_D2_c_y_6k   = hi_blk[0];
  assign bus.Hi_D2_c_y_6k_1 = hi_blk[1];
  assign bus.Hi_D2_c_y_6k_2 = hi_blk[2];
  assign bus.Hi_D2_c_y_6k_3 = hi_blk[3];
  assign bus.Hi_D2_c_y_6k_4 = hi_blk[4];
  assign bus.Hi_D2_c_y_6k_5 = hi_blk[5];
  assign bus.Hi_D2_valid    = hi_valid;

endmodule

// File: tb/tb_dwt_level2.sv
// Scoreboard bench for dwt_level2: a sample-history reference model pushes
// expected blocks and strobe cycles; a negedge monitor pops and compares.
module tb_dwt_level2;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dwt_level2_if bus ();
  dwt_level2 dut (.clk(clk), .rstn(rstn), .bus(bus));

  logic signed [24:0] lo_obs [6];
  logic signed [24:0] hi_obs [6];
  assign lo_obs[0] = bus.Lo_D2_c_y_6k;   assign hi_obs[0] = bus.Hi_D2_c_y_6k;
  assign lo_obs[1] = bus.Lo_D2_c_y_6k_1; assign hi_obs[1] = bus.Hi_D2_c_y_6k_1;
  assign lo_obs[2] = bus.Lo_D2_c_y_6k_2; assign hi_obs[2] = bus.Hi_D2_c_y_6k_2;
  assign lo_obs[3] = bus.Lo_D2_c_y_6k_3; assign hi_obs[3] = bus.Hi_D2_c_y_6k_3;
  assign lo_obs[4] = bus.Lo_D2_c_y_6k_4; assign hi_obs[4] = bus.Hi_D2_c_y_6k_4;
  assign lo_obs[5] = bus.Lo_D2_c_y_6k_5; assign hi_obs[5] = bus.Hi_D2_c_y_6k_5;

  // Reference model state: every sample accepted since reset, kept outputs.
  int     lo_h [4] = '{-17, 29, 107, 62};
  int     hi_g [4] = '{-62, 107, -29, -17};
  int     hist [$];
  longint kept_lo [$];
  longint kept_hi [$];
  longint exp_lo [$];
  longint exp_hi [$];
  int     exp_cyc [$];
  longint last_lo [6];
  longint last_hi [6];
  int     strobes = 0;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic longint wrap25(input longint v);
    longint m;
    m = v & 64'h1FF_FFFF;
    if (m >= 64'sd16777216) m = m - 64'sd33554432;
    return m;
  endfunction

  function automatic longint fir(input int coef [4], input int n);
    longint acc = 0;
    for (int j = 0; j < 4; j++)
      if (n - j >= 0) acc += longint'(coef[j]) * longint'(hist[n - j]);
    return wrap25(acc >>> 7);  // arithmetic shift on a signed longint floors
  endfunction

  // Accept one sample into the model; strobe expected in the cycle after the accepting edge.
  task automatic model_accept(input int x, input int strobe_cyc);
    int n;
    hist.push_back(x);
    n = hist.size() - 1;
    if (n % 2 == 1) begin
      kept_lo.push_back(fir(lo_h, n));
      kept_hi.push_back(fir(hi_g, n));
      if (kept_lo.size() == 6) begin
        for (int i = 0; i < 6; i++) begin
          exp_lo.push_back(kept_lo.pop_front());
          exp_hi.push_back(kept_hi.pop_front());
        end
        exp_cyc.push_back(strobe_cyc);
      end
    end
  endtask

  task automatic drive(input bit v, input int x);
    @(posedge clk);
    #1;
    bus.Lo_D_down_valid = v;
    bus.Lo_D_down_y_k   = 25'(x);
    if (v) model_accept(x, cyc + 1);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) drive(1'b0, 0);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #1;
    bus.Lo_D_down_valid = 1'b0;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    rstn = 1'b0;
    hist.delete();
    kept_lo.delete();
    kept_hi.delete();
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      check({tag, "_lo_zero"}, longint'(lo_obs[i]), 0);
      check({tag, "_hi_zero"}, longint'(hi_obs[i]), 0);
    end
    check({tag, "_strobe_low"}, longint'({bus.Lo_D2_valid, bus.Hi_D2_valid}), 0);
  endtask

  task automatic check_block(input string tag, input longint lo [6], input longint hi [6]);
    for (int i = 0; i < 6; i++) begin
      check({tag, "_lo"}, last_lo[i], lo[i]);
      check({tag, "_hi"}, last_hi[i], hi[i]);
    end
  endtask

  // Monitor: every strobe must match the head of the scoreboard, in value and cycle.
  always @(negedge clk) begin
    if (bus.Lo_D2_valid || bus.Hi_D2_valid) begin
      strobes++;
      check("strobe_pair", longint'(bus.Hi_D2_valid), longint'(bus.Lo_D2_valid));
      for (int i = 0; i < 6; i++) begin
        last_lo[i] = longint'(lo_obs[i]);
        last_hi[i] = longint'(hi_obs[i]);
      end
      if (exp_cyc.size() == 0) begin
        check("unexpected_strobe", longint'(cyc), -1);
      end else begin
        check("strobe_cycle", longint'(cyc), longint'(exp_cyc.pop_front()));
        for (int i = 0; i < 6; i++) begin
          check("blk_lo", last_lo[i], exp_lo.pop_front());
          check("blk_hi", last_hi[i], exp_hi.pop_front());
        end
      end
    end
  end

  longint imp_lo [6] = '{29, 62, 0, 0, 0, 0};
  longint imp_hi [6] = '{107, -17, 0, 0, 0, 0};
  longint dc1_lo [6] = '{9, 141, 141, 141, 141, 141};
  longint dc1_hi [6] = '{35, -1, -1, -1, -1, -1};
  longint dc2_lo [6] = '{141, 141, 141, 141, 141, 141};
  longint dc2_hi [6] = '{-1, -1, -1, -1, -1, -1};

  task automatic impulse(input bit gaps);
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, (i == 0) ? 128 : 0);
      if (gaps) drive(1'b0, 0);
    end
    idle(3);
  endtask

  initial begin
    int s0;
    bus.Lo_D_down_valid = 1'b0;
    bus.Lo_D_down_y_k   = '0;

    do_reset("reset");

    impulse(1'b0);
    check_block("impulse", imp_lo, imp_hi);

    do_reset("reset_dc");
    for (int i = 0; i < 12; i++) drive(1'b1, 100);
    idle(2);
    check_block("dc1", dc1_lo, dc1_hi);
    for (int i = 0; i < 12; i++) drive(1'b1, 100);
    idle(2);
    check_block("dc2", dc2_lo, dc2_hi);

    do_reset("reset_gap");
    s0 = strobes;
    impulse(1'b1);
    check("gap_strobe_count", longint'(strobes - s0), 1);
    check_block("gap_impulse", imp_lo, imp_hi);

    do_reset("reset_wrap");
    for (int i = 0; i < 24; i++) drive(1'b1, 16777215);
    idle(2);
    check("wrap_lo5", last_lo[5], -64'sd9830402);
    check("wrap_lo0", last_lo[0], -64'sd9830402);

    do_reset("reset_pre_mid");
    for (int i = 0; i < 7; i++) drive(1'b1, 1000 + i * 37);
    s0 = strobes;
    do_reset("reset_mid");
    check("mid_no_strobe", longint'(strobes - s0), 0);
    impulse(1'b0);
    check_block("mid_impulse", imp_lo, imp_hi);

    do_reset("reset_rand");
    s0 = strobes;
    for (int i = 0; i < 60; i++) drive(1'b1, int'($urandom_range(98)) - 49);
    idle(3);
    check("rand_strobe_count", longint'(strobes - s0), 5);

    check("scoreboard_drained", longint'(exp_cyc.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dwt_level2.md
Name: dwt_level2

Overview:
- Second-level discrete wavelet transform stage.
- Consumes the decimated low-pass stream from level 1 and applies a 4-tap Daubechies-2 low-pass and high-pass analysis filter pair, each followed by downsampling by 2.
- Packs each filter's decimated outputs into blocks of six words, presented in parallel with a valid strobe.
- Sits between the level-1 DWT stage and downstream coefficient storage/processing.

Parameters:
- w_in, 9: sample width of the level-1 input; informational, carried for hierarchy consistency.
- y_out, 25: width of the input sample and of every output coefficient (signed, two's complement).
- c_in, 9: width of the filter coefficients (signed, Q1.7 fixed point).

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  synchronous, active-high reset. The port keeps the codebase name; high means reset.
- Lo_D_down_valid  input  1  qualifies Lo_D_down_y_k this cycle.
- Lo_D_down_y_k  input  y_out  signed level-1 low-pass decimated sample.
- Hi_D2_c_y_6k .. Hi_D2_c_y_6k_5  output  y_out each  six high-pass decimated coefficients; _6k is the oldest, _6k_5 the newest.
- Hi_D2_valid  output  1  one-cycle strobe: the Hi block is updated.
- Lo_D2_c_y_6k .. Lo_D2_c_y_6k_5  output  y_out each  six low-pass decimated coefficients, same ordering.
- Lo_D2_valid  output  1  one-cycle strobe: the Lo block is updated.

Behaviour:
- Coefficients (c_in-bit signed, scale 2^7):
  - Lo h = [-17, 29, 107, 62]
  - Hi g = [-62, 107, -29, -17]
- Filtering: y[n] = (sum over j=0..3 of h[j]·x[n-j]) >>> 7.
  - n indexes accepted samples only.
  - x[n-j] = 0 for samples before reset.
  - Products and sum use full precision (y_out+c_in+2 bits). The arithmetic right shift floors. The result is truncated to the y_out LSBs (wrap, no saturation).
- Sample acceptance:
  - A sample is accepted only on cycles with Lo_D_down_valid=1.
  - With valid=0, the delay line, phase and counters hold.
- Decimation: a 1-bit phase toggles per accepted sample, starting at 0 after reset. Outputs are kept for odd n (n = 1, 3, 5, …) only.
- Packing:
  - A 3-bit slot counter (0..5) places each kept output into a shadow slot.
  - When slot 5 is written, all six shadow words are copied to the output registers at that clock edge.
  - Hi_D2_valid and Lo_D2_valid are high for exactly the following cycle, always together. The counter wraps to 0.
  - Latency: the strobe is visible in the cycle after the edge that accepted the 12th sample of a block.
- Outputs hold their values between strobes.
- Reset (rstn=1 at a clock edge) clears:
  - all outputs and both strobes;
  - the delay line, phase, slot counter and shadow registers.
- Reset mid-block discards the partial block; the next block begins from n=0.
- Back-to-back valid inputs give one strobe every 12 cycles. No backpressure.

Decomposition:
- Shared package dwt_pkg: y_out, c_in, shift constant 7, LO_COEF[4] and HI_COEF[4] arrays, block length 6.
- One natural sub-module, dwt_fir_decim (parameterised by its coefficient set): delay line, MAC, phase, slot packing. It is instantiated twice (Lo, Hi) sharing the input.
- The top module ties the two valid strobes and the output ports.

Test Plan:
- Impulse: reset, then accept x = 128, 0, 0, … (12 samples).
  - Lo block = 29, 62, 0, 0, 0, 0.
  - Hi block = 107, -17, 0, 0, 0, 0.
  - Both strobes high for one cycle after the 12th accept.
- DC: x = 100 constant, 12 samples.
  - Lo block = 9, 141, 141, 141, 141, 141.
  - Hi block = 35, -1, -1, -1, -1, -1.
  - A second block of 12 gives Lo all 141 and Hi all -1.
- Valid gaps: the impulse test with valid=0 inserted every other cycle gives identical blocks. The strobe occurs after the 12th accepted sample; there is no strobe during gaps.
- Wrap: constant x = 16777215. Steady-state Lo word = -9830402, from 25-bit truncation of 23724030.
- Reset mid-block: accept 7 samples, assert rstn for 1 cycle, then run the impulse test.
  - Outputs read 0 right after reset, with no strobe.
  - The subsequent block matches the impulse test exactly.
- Random stream (values -49..49, continuous valid): compare every block against a reference model. One strobe every 12 cycles.
